// File: rtl/stencil_pkg.sv
// Shared constants, capture tag and tap indexing for the stencil window front end.
// Optional build macro used by the top: STENCIL_WINDOW_CNT_EN (window/frame counters).
package stencil_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int WIN_TAPS   = 9;
    localparam int TAP_CENTER = 4;

    // Per-pixel flags decided at pop time and carried with the returning word.
    typedef struct packed {
        logic emit;
        logic last;
    } cap_tag_t;

    function automatic int tap_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/stencil_line_ram.sv
// One image row of pixels: simple dual-port RAM with a registered, enabled read port.
module stencil_line_ram
    import stencil_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = DEF_DATA_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read data holds between reads so a stalled capture can still use it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stencil_window.sv
// Raster-to-3x3-window front end: FIFO pop control, skid, two line RAMs, output register.
// Define STENCIL_WINDOW_CNT_EN to add the frame_cnt / win_cnt outputs.
module stencil_window
    import stencil_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       in_rd_en,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_empty,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [WIN_TAPS*DATA_W-1:0] win_data,
    output logic                       win_last
`ifdef STENCIL_WINDOW_CNT_EN
    ,
    output logic [15:0]                frame_cnt,
    output logic [31:0]                win_cnt
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]             col_reg, pend_col_reg, skid_col_reg, cap_col;
    logic [RW-1:0]             row_reg;
    logic                      run_reg, pend_reg, skid_full_reg;
    cap_tag_t                  pend_tag_reg, skid_tag_reg, cap_tag;
    logic [DATA_W-1:0]         skid_pix_reg, skid_l0_reg, skid_l1_reg;
    logic [DATA_W-1:0]         rd0, rd1, cap_pix, cap_l0, cap_l1;
    logic [DATA_W-1:0]         new_col [3];
    // Columns c=0 and c=1 of the next window; c=2 is always the incoming column.
    logic [DATA_W-1:0]         sr0_reg [3];
    logic [DATA_W-1:0]         sr1_reg [3];
    logic                      win_valid_reg, win_last_reg;
    logic [WIN_TAPS*DATA_W-1:0] win_data_reg, win_next;
    logic                      stall, do_cap;

    assign stall    = win_valid_reg && !win_ready;
    assign in_rd_en = run_reg && !in_empty && !skid_full_reg && !stall;
    assign do_cap   = (skid_full_reg || pend_reg) && !stall;

    assign cap_pix = skid_full_reg ? skid_pix_reg : in_data;
    assign cap_l0  = skid_full_reg ? skid_l0_reg  : rd0;
    assign cap_l1  = skid_full_reg ? skid_l1_reg  : rd1;
    assign cap_col = skid_full_reg ? skid_col_reg : pend_col_reg;
    assign cap_tag = skid_full_reg ? skid_tag_reg : pend_tag_reg;

    assign new_col[0] = cap_l1;
    assign new_col[1] = cap_l0;
    assign new_col[2] = cap_pix;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            assign win_next[tap_idx(gi, 0)*DATA_W +: DATA_W] = sr0_reg[gi];
            assign win_next[tap_idx(gi, 1)*DATA_W +: DATA_W] = sr1_reg[gi];
            assign win_next[tap_idx(gi, 2)*DATA_W +: DATA_W] = new_col[gi];
        end
    endgenerate

    stencil_line_ram #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_line0 (
        .clk(clk), .wr_en(do_cap), .wr_addr(cap_col), .wr_data(cap_pix),
        .rd_en(in_rd_en), .rd_addr(col_reg), .rd_data(rd0)
    );

    stencil_line_ram #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_line1 (
        .clk(clk), .wr_en(do_cap), .wr_addr(cap_col), .wr_data(cap_l0),
        .rd_en(in_rd_en), .rd_addr(col_reg), .rd_data(rd1)
    );

    // Position counters advance on the pop so back-to-back reads use the right column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_reg      <= 1'b0;
            pend_reg     <= 1'b0;
            col_reg      <= '0;
            row_reg      <= '0;
            pend_col_reg <= '0;
            pend_tag_reg <= '0;
        end else begin
            run_reg  <= 1'b1;
            pend_reg <= in_rd_en;
            if (in_rd_en) begin
                pend_col_reg      <= col_reg;
                pend_tag_reg.emit <= (row_reg >= RW'(2)) && (col_reg >= CW'(2));
                pend_tag_reg.last <= (row_reg == RW'(IMG_H-1)) && (col_reg == CW'(IMG_W-1));
                if (col_reg == CW'(IMG_W-1)) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == RW'(IMG_H-1)) ? '0 : row_reg + RW'(1);
                end else begin
                    col_reg <= col_reg + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_full_reg <= 1'b0;
            skid_pix_reg  <= '0;
            skid_l0_reg   <= '0;
            skid_l1_reg   <= '0;
            skid_col_reg  <= '0;
            skid_tag_reg  <= '0;
        end else if (pend_reg && stall) begin
            skid_full_reg <= 1'b1;
            skid_pix_reg  <= in_data;
            skid_l0_reg   <= rd0;
            skid_l1_reg   <= rd1;
            skid_col_reg  <= pend_col_reg;
            skid_tag_reg  <= pend_tag_reg;
        end else if (do_cap) begin
            skid_full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                sr0_reg[i] <= '0;
                sr1_reg[i] <= '0;
            end
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
            win_data_reg  <= '0;
        end else begin
            if (do_cap) begin
                for (int i = 0; i < 3; i++) begin
                    sr0_reg[i] <= sr1_reg[i];
                    sr1_reg[i] <= new_col[i];
                end
            end
            if (do_cap && cap_tag.emit) begin
                win_valid_reg <= 1'b1;
                win_data_reg  <= win_next;
                win_last_reg  <= cap_tag.last;
            end else if (win_valid_reg && win_ready) begin
                win_valid_reg <= 1'b0;
                win_last_reg  <= 1'b0;
            end
        end
    end

    assign win_valid = win_valid_reg;
    assign win_data  = win_data_reg;
    assign win_last  = win_last_reg;

`ifdef STENCIL_WINDOW_CNT_EN
    logic [15:0] frame_cnt_reg;
    logic [31:0] win_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_reg <= '0;
            win_cnt_reg   <= '0;
        end else if (win_valid_reg && win_ready) begin
            win_cnt_reg <= win_cnt_reg + 32'd1;
            if (win_last_reg) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_reg;
    assign win_cnt   = win_cnt_reg;
`endif

endmodule

// File: tb/tb_stencil_window.sv
// Self-checking bench for stencil_window: FIFO/consumer models plus a frame-level window reference.
module tb_stencil_window;
    import stencil_pkg::*;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int DW   = 32;
    localparam int NPIX = W * H;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_rd_en;
    logic [DW-1:0]   in_data = '0;
    logic            in_empty = 1'b1;
    logic            win_valid;
    logic            win_ready = 1'b0;
    logic [9*DW-1:0] win_data;
    logic            win_last;
`ifdef STENCIL_WINDOW_CNT_EN
    logic [15:0]     frame_cnt;
    logic [31:0]     win_cnt;
`endif

    stencil_window #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk(clk),
        .reset(reset),
        .in_rd_en(in_rd_en),
        .in_data(in_data),
        .in_empty(in_empty),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_data(win_data),
        .win_last(win_last)
`ifdef STENCIL_WINDOW_CNT_EN
        ,
        .frame_cnt(frame_cnt),
        .win_cnt(win_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*DW-1:0] data;
        logic [DW-1:0]   centre;
        logic            last;
    } exp_t;

    exp_t            exp_q[$];
    logic [DW-1:0]   fifo_q[$];
    int              checks = 0;
    int              failures = 0;
    int              ready_mode = 0;
    int              gap_mode = 0;
    int              gap_left = 0;
    int              stall_left = 0;
    bit              first_seen = 0;
    int              acc_count = 0;
    int              last_count = 0;
    logic            prev_stalled = 1'b0;
    logic [9*DW-1:0] prev_data = '0;
    logic            prev_last = 1'b0;

    task automatic check(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every interior pixel (r,c) of the frame yields one window centred on (r-1,c-1).
    task automatic send_frame(input logic [DW-1:0] pix [NPIX]);
        for (int i = 0; i < NPIX; i++) fifo_q.push_back(pix[i]);
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                exp_t e;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        e.data[(3*rr+cc)*DW +: DW] = pix[(r-2+rr)*W + (c-2+cc)];
                e.centre = pix[(r-1)*W + (c-1)];
                e.last   = (r == H-1) && (c == W-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_mode(input int rm, input int gm);
        ready_mode = rm;
        gap_mode   = gm;
        first_seen = 0;
        gap_left   = 0;
        stall_left = 0;
    endtask

    task automatic tick();
        logic pop_now;
        @(negedge clk);
        if (ready_mode == 1 && win_valid && !first_seen) begin
            first_seen = 1;
            stall_left = 5;
        end
        case (ready_mode)
            0:       win_ready = 1'b1;
            1:       win_ready = (stall_left == 0);
            default: win_ready = ($urandom_range(0, 9) < 7);
        endcase
        if (stall_left > 0) stall_left--;
        if (gap_mode == 2) begin
            in_empty = (fifo_q.size() == 0) || ($urandom_range(0, 9) < 3);
        end else begin
            in_empty = (fifo_q.size() == 0) || (gap_left > 0);
            if (gap_left > 0) gap_left--;
        end
        #1;
        pop_now = in_rd_en;
        if (in_empty) check("rd_en_while_empty", in_rd_en, 1'b0);
        if (win_valid && !win_ready) check("rd_en_while_stalled", in_rd_en, 1'b0);
        if (prev_stalled) begin
            check("hold_valid", win_valid, 1'b1);
            check("hold_data", win_data, prev_data);
            check("hold_last", win_last, prev_last);
        end
        if (win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_window", win_valid, 1'b0);
            end else begin
                exp_t e = exp_q.pop_front();
                check("win_data", win_data, e.data);
                check("win_centre", win_data[TAP_CENTER*DW +: DW], e.centre);
                check("win_last", win_last, e.last);
                acc_count++;
                if (e.last) last_count++;
            end
        end
        prev_stalled = win_valid && !win_ready;
        prev_data    = win_data;
        prev_last    = win_last;
        @(posedge clk);
        #1;
        if (pop_now && fifo_q.size() > 0) begin
            in_data = fifo_q.pop_front();
            if (gap_mode == 1) gap_left = 3;
        end
    endtask

    task automatic run_drain(input string name, input int budget);
        int n = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0 || win_valid) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_all_windows_seen"}, exp_q.size(), 0);
        check({name, "_fifo_drained"}, fifo_q.size(), 0);
        repeat (4) tick();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            in_empty  = 1'b0;
            win_ready = 1'b1;
            #1;
            check("rst_in_rd_en", in_rd_en, 1'b0);
            check("rst_win_valid", win_valid, 1'b0);
            check("rst_win_data", win_data, '0);
            check("rst_win_last", win_last, 1'b0);
`ifdef STENCIL_WINDOW_CNT_EN
            check("rst_frame_cnt", frame_cnt, '0);
            check("rst_win_cnt", win_cnt, '0);
`endif
        end
        @(negedge clk);
        reset        = 1'b1;
        in_empty     = 1'b1;
        prev_stalled = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        gap_left     = 0;
        stall_left   = 0;
        acc_count    = 0;
        last_count   = 0;
    endtask

    initial begin
        logic [DW-1:0] pix  [NPIX];
        logic [DW-1:0] pix2 [NPIX];
        int n;

        for (int i = 0; i < NPIX; i++) begin
            pix[i]  = DW'(i);
            pix2[i] = DW'(100 + i);
        end

        do_reset(3);

        // Plain frame 0..15, consumer always ready.
        set_mode(0, 0);
        send_frame(pix);
        run_drain("seq", 200);
        check("seq_window_count", acc_count, 4);

        // Consumer stalls 5 cycles on the first window.
        set_mode(1, 0);
        send_frame(pix);
        run_drain("stall", 200);
        check("stall_window_count", acc_count, 8);

        // Three empty FIFO cycles between every pixel.
        set_mode(0, 1);
        send_frame(pix);
        run_drain("gaps", 400);

        // Two frames back to back.
        set_mode(0, 0);
        send_frame(pix);
        send_frame(pix2);
        run_drain("b2b", 300);
        check("b2b_last_count", last_count, 5);

        // Reset mid-frame while pixel 9 is still in flight, then resend.
        for (int i = 0; i < 10; i++) fifo_q.push_back(DW'(i));
        n = 0;
        while (fifo_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        check("partial_popped", fifo_q.size(), 0);
        do_reset(3);
        set_mode(0, 0);
        send_frame(pix);
        run_drain("after_reset", 200);
        check("after_reset_count", acc_count, 4);
        send_frame(pix2);
        run_drain("after_reset_f2", 200);
`ifdef STENCIL_WINDOW_CNT_EN
        check("frame_cnt", frame_cnt, 16'd2);
        check("win_cnt", win_cnt, 32'd8);
`endif

        // Random pixels, random consumer stalls and FIFO gaps.
        set_mode(2, 2);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) pix[i] = $urandom;
            send_frame(pix);
        end
        run_drain("random", 3000);
        check("random_last_count", last_count, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stencil_window.md
# stencil_window

Raster-to-window front end for the stencil datapath. Sits between the 32x512 input FIFO and the stencil compute core. Pops one 32-bit pixel per cycle from the FIFO read port. Keeps two image rows in line RAMs and emits one complete 3x3 neighbourhood per interior pixel over a valid/ready handshake, so the core never re-reads data.

## Interface
- IMG_W, default 64: pixels per row; legal range 3..512.
- IMG_H, default 64: rows per frame; legal range 3..65535.
- DATA_W, default 32: pixel width.
- clk, input, 1: the single clock for the block; all logic on rising edge.
- reset, input, 1: asynchronous, active-low; assert at any time, deassert synchronously to clk.
- in_rd_en, output, 1: FIFO pop; FIFO data is valid on in_data one cycle later.
- in_data, input, DATA_W: FIFO read data.
- in_empty, input, 1: FIFO empty.
- win_valid, output, 1: win_data holds a valid window.
- win_ready, input, 1: consumer accepts the window.
- win_data, output, 9*DATA_W: tap k occupies [k*DATA_W +: DATA_W], with k = 3*r + c.
  - r=0 is the oldest row; c=0 is the leftmost column.
  - Tap 4 is the centre.
- win_last, output, 1: qualifies the final window of a frame.

## Operation
- Input is in raster order with no header. Frame boundaries are implicit: every IMG_W*IMG_H pixels form one frame. Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the pixel being captured.
- in_rd_en = !in_empty && !skid_full && !(win_valid && !win_ready).
- At most one pop is in flight. When a returned word cannot be consumed because the output is stalled, it goes into a 1-entry skid register.
- Line RAM reads:
  - Issued on the pop cycle at address col.
  - line0 returns the pixel at (row-1, col); line1 returns the pixel at (row-2, col).
  - RAM data arrives on the same edge as in_data.
- On capture:
  - The new pixel is written to line0[col].
  - The old line0[col] is written to line1[col].
  - The 3x3 shift register shifts left and loads column {line1, line0, pixel} into c=2.
- Output condition: a window is produced only when row>=2 && col>=2. Its centre is pixel (row-1, col-1).
- Output count: (IMG_W-2)*(IMG_H-2) windows per frame. All other captures update state silently.
- win_last is set on the window captured at (IMG_H-1, IMG_W-1). Afterwards col and row wrap to 0 and the next frame starts with no idle cycle.
- Line RAM contents are never cleared. Stale rows are harmless because no window is emitted until row 2.
- Handshake rule: while win_valid && !win_ready, win_data, win_last and win_valid hold stable.

## Timing
- Reset values: in_rd_en=0, win_valid=0, win_last=0, win_data=0. Counters, skid register and shift register are cleared.
- Latency: 2 cycles from in_rd_en to win_valid on an emitting pixel.
- Throughput: 1 window per cycle when the FIFO is non-empty and win_ready=1.
- Empty FIFO: in_rd_en=0, state holds, win_valid drops after the current window is accepted.
- Simultaneous accept and new capture: the window is replaced on the same edge and win_valid stays 1.
- Skid register: drains before any new pop; that costs one bubble cycle per stall episode.
- Reset mid-frame: all counters return to 0. The next popped word is treated as pixel (0,0). An in-flight pop is discarded.

## Configuration
- STENCIL_WINDOW_CNT_EN defined: adds two outputs.
  - frame_cnt [15:0]: increments on accepted win_last.
  - win_cnt [31:0]: increments on every accepted window.
  - Both wrap, and both reset to 0.
- Undefined: neither port nor its counters exist; behaviour is otherwise identical.

## Structure
- Package stencil_pkg:
  - DATA_W default.
  - WIN_TAPS=9 and TAP_CENTER=4.
  - A function tap_idx(r,c) = 3*r + c.
- Sub-module stencil_line_ram: simple dual-port RAM, IMG_W x DATA_W, 1-cycle registered read, write-before-read irrelevant (different cycles per address). Instantiated twice (line0, line1).
- Top: counters, pop/skid control, shift register, output register.

## Test plan
- IMG_W=4, IMG_H=4, input 0..15, win_ready=1 -> exactly 4 windows:
  - First = {0,1,2,4,5,6,8,9,10}.
  - Fourth = {5,6,7,9,10,11,13,14,15} with win_last=1 only there.
- Same frame with win_ready=0 for 5 cycles after the first window -> win_data stays {0,1,2,...,10}, in_rd_en=0 after the skid fills, and no window is lost or duplicated.
- FIFO empty for 3 cycles between every pixel -> identical window sequence; in_rd_en never asserted while in_empty=1.
- Two back-to-back 4x4 frames (0..15, then 100..115) -> 8 windows. Frame 2's first window = {100,101,102,104,105,106,108,109,110}, with no stale data.
- Assert reset after pixel 9, then resend 0..15 -> outputs are 0 during reset, then exactly 4 correct windows.
- With STENCIL_WINDOW_CNT_EN, after two 4x4 frames -> frame_cnt=2, win_cnt=8.
